// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared encodings and sizes for the fetch prefetch buffer.
package fetch_prefetch_buffer_pkg;

  typedef enum logic [1:0] {
    FQ_IDLE  = 2'd0,
    FQ_WAIT  = 2'd1,
    FQ_FLUSH = 2'd2
  } fq_state_e;

  localparam int unsigned IMEM_WORD_BYTES = 8;
  localparam int unsigned MAX_INSTR_BYTES = 10;
  localparam int unsigned LEN_W           = 4;

endpackage

// File: rtl/fetch_byte_queue.sv
// Byte shift buffer: drop n bytes from the head, then append part of a word at the new tail.
module fetch_byte_queue
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int unsigned QBYTES = 16,
  localparam int unsigned CW    = $clog2(QBYTES + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         flush_i,
  input  logic                         shift_i,
  input  logic [LEN_W-1:0]             shift_len_i,
  input  logic                         append_i,
  input  logic [63:0]                  append_data_i,
  input  logic [2:0]                   append_skip_i,
  output logic [8*MAX_INSTR_BYTES-1:0] window_o,
  output logic [CW-1:0]                count_o,
  output logic [CW-1:0]                count_next_c
);

  localparam int unsigned IW = $clog2(QBYTES);

  logic [7:0]    q_q [QBYTES];
  logic [7:0]    q_d [QBYTES];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [7:0]    word_b [IMEM_WORD_BYTES];

  int unsigned shn;
  int unsigned nb;
  int unsigned base;
  int unsigned src;

  // Split the incoming memory word into bytes.
  always_comb begin
    for (int unsigned j = 0; j < IMEM_WORD_BYTES; j++) begin
      word_b[j] = append_data_i[8*j +: 8];
    end
  end

  // Next queue contents: shift first, append at the post-shift tail; bytes past count stay zero.
  always_comb begin
    shn  = shift_i ? 32'(shift_len_i) : 32'd0;
    nb   = append_i ? (IMEM_WORD_BYTES - 32'(append_skip_i)) : 32'd0;
    base = 32'(count_q) - shn;
    src  = 32'd0;
    for (int unsigned i = 0; i < QBYTES; i++) begin
      src    = i + shn;
      q_d[i] = (src < QBYTES) ? q_q[IW'(src)] : 8'h00;
      if ((i >= base) && (i < base + nb)) begin
        q_d[i] = word_b[3'(i - base + 32'(append_skip_i))];
      end
    end
    count_d = CW'(base + nb);
    if (flush_i) begin
      count_d = '0;
      for (int unsigned i = 0; i < QBYTES; i++) begin
        q_d[i] = 8'h00;
      end
    end
  end

  // Queue storage and fill level.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      for (int unsigned i = 0; i < QBYTES; i++) begin
        q_q[i] <= 8'h00;
      end
    end else begin
      count_q <= count_d;
      for (int unsigned i = 0; i < QBYTES; i++) begin
        q_q[i] <= q_d[i];
      end
    end
  end

  for (genvar g = 0; g < MAX_INSTR_BYTES; g++) begin : g_window
    assign window_o[8*g +: 8] = q_q[g];
  end

  assign count_o      = count_q;
  assign count_next_c = count_d;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Prefetches aligned 8-byte words and presents a 10-byte instruction window at pc_o.
module fetch_prefetch_buffer
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int unsigned IMEM_AW = 10,
  parameter int unsigned QBYTES  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         redirect_i,
  input  logic [63:0]                  redirect_pc_i,
  output logic                         imem_req_o,
  output logic [63:0]                  imem_addr_o,
  input  logic                         imem_rvalid_i,
  input  logic [63:0]                  imem_rdata_i,
  output logic [8*MAX_INSTR_BYTES-1:0] instr_o,
  output logic [63:0]                  pc_o,
  output logic                         instr_valid_o,
  input  logic                         consume_i,
  input  logic [LEN_W-1:0]             consume_len_i
);

  localparam int unsigned CW = $clog2(QBYTES + 1);

  fq_state_e     state_q, state_d;
  logic [63:0]   fetch_addr_q, fetch_addr_d;
  logic [2:0]    skip_q, skip_d;
  logic [63:0]   pc_q, pc_d;
  logic          req_q, req_d;
  logic [63:0]   addr_q, addr_d;
  logic          valid_q, valid_d;

  logic          consume_en;
  logic          append_en;
  logic          exhausted;
  logic          exhausted_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  fetch_byte_queue #(.QBYTES(QBYTES)) u_queue (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .flush_i       (redirect_i),
    .shift_i       (consume_en),
    .shift_len_i   (consume_len_i),
    .append_i      (append_en),
    .append_data_i (imem_rdata_i),
    .append_skip_i (skip_q),
    .window_o      (instr_o),
    .count_o       (count),
    .count_next_c  (count_next)
  );

  assign exhausted      = |fetch_addr_q[63:IMEM_AW];
  assign exhausted_next = |fetch_addr_d[63:IMEM_AW];

  // Request FSM, address generation, PC tracking and next-cycle valid.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    skip_d       = skip_q;
    pc_d         = pc_q;
    req_d        = 1'b0;
    addr_d       = addr_q;
    append_en    = 1'b0;
    consume_en   = consume_i && valid_q && !redirect_i;

    case (state_q)
      FQ_IDLE: begin
        if (!redirect_i && !exhausted &&
            (32'(count) <= QBYTES - IMEM_WORD_BYTES)) begin
          req_d        = 1'b1;
          addr_d       = fetch_addr_q;
          fetch_addr_d = fetch_addr_q + 64'(IMEM_WORD_BYTES);
          state_d      = FQ_WAIT;
        end
      end
      FQ_WAIT: begin
        if (redirect_i) begin
          state_d = imem_rvalid_i ? FQ_IDLE : FQ_FLUSH;
        end else if (imem_rvalid_i) begin
          append_en = 1'b1;
          skip_d    = 3'd0;
          state_d   = FQ_IDLE;
        end
      end
      FQ_FLUSH: begin
        if (imem_rvalid_i) begin
          state_d = FQ_IDLE;
        end
      end
      default: state_d = FQ_IDLE;
    endcase

    if (consume_en) begin
      pc_d = pc_q + 64'(consume_len_i);
    end

    if (redirect_i) begin
      pc_d         = redirect_pc_i;
      fetch_addr_d = {redirect_pc_i[63:3], 3'b000};
      skip_d       = redirect_pc_i[2:0];
    end

    valid_d = (32'(count_next) >= MAX_INSTR_BYTES) ||
              (exhausted_next && (state_d == FQ_IDLE) && (count_next != '0));
  end

  // Control and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= FQ_IDLE;
      fetch_addr_q <= '0;
      skip_q       <= '0;
      pc_q         <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      skip_q       <= skip_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: directed scenarios plus random traffic against a byte-queue model.
module tb_fetch_prefetch_buffer;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        consume;
  logic [3:0]  consume_len;
  logic        rvalid;
  logic [63:0] rdata;

  logic        rst0, rst1, rvalid0, rvalid1;
  logic        req0, req1, valid0, valid1;
  logic [63:0] addr0, addr1, pc0, pc1;
  logic [79:0] instr0, instr1;

  logic        obs_req, obs_valid;
  logic [63:0] obs_addr, obs_pc;
  logic [79:0] obs_instr;

  assign rst0    = rst_n & ~sel;
  assign rst1    = rst_n & sel;
  assign rvalid0 = rvalid & ~sel;
  assign rvalid1 = rvalid & sel;

  assign obs_req   = sel ? req1   : req0;
  assign obs_addr  = sel ? addr1  : addr0;
  assign obs_pc    = sel ? pc1    : pc0;
  assign obs_valid = sel ? valid1 : valid0;
  assign obs_instr = sel ? instr1 : instr0;

  fetch_prefetch_buffer #(.IMEM_AW(10), .QBYTES(16)) dut0 (
    .clk_i(clk), .rst_n_i(rst0), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req0), .imem_addr_o(addr0), .imem_rvalid_i(rvalid0), .imem_rdata_i(rdata),
    .instr_o(instr0), .pc_o(pc0), .instr_valid_o(valid0),
    .consume_i(consume), .consume_len_i(consume_len)
  );

  fetch_prefetch_buffer #(.IMEM_AW(5), .QBYTES(16)) dut1 (
    .clk_i(clk), .rst_n_i(rst1), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(req1), .imem_addr_o(addr1), .imem_rvalid_i(rvalid1), .imem_rdata_i(rdata),
    .instr_o(instr1), .pc_o(pc1), .instr_valid_o(valid1),
    .consume_i(consume), .consume_len_i(consume_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [1024];

  // Memory responder state
  bit          pend;
  logic [63:0] pend_addr;
  int          dly;
  int          lat_min, lat_max;
  bit          rst_drv;
  bit          rvalid_seen, req_seen;
  logic [63:0] last_req_addr;

  // Reference model: bytes of the window queue plus request bookkeeping
  logic [7:0]  mq [$];
  logic [63:0] m_pc, m_faddr, m_addr;
  int          m_skip;
  bit          m_out, m_drop, m_req, m_valid;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    for (int n = 0; n < 8; n++) w[8*n +: 8] = mem[10'(a + 64'(n))];
    return w;
  endfunction

  function automatic bit exh(input logic [63:0] a);
    int aw;
    aw = sel ? 5 : 10;
    return (a >> aw) != 64'd0;
  endfunction

  function automatic logic [79:0] exp_instr();
    logic [79:0] e;
    e = '0;
    for (int k = 0; k < 10; k++) if (k < mq.size()) e[8*k +: 8] = mq[k];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_step();
    int  pre_cnt;
    bit  pre_out;
    if (!rst_n) begin
      mq.delete();
      m_pc = '0; m_faddr = '0; m_addr = '0; m_skip = 0;
      m_out = 0; m_drop = 0; m_req = 0; m_valid = 0;
      return;
    end
    pre_cnt = mq.size();
    pre_out = m_out;
    m_req   = 0;
    if (redirect) begin
      mq.delete();
      m_pc    = redirect_pc;
      m_faddr = {redirect_pc[63:3], 3'b000};
      m_skip  = int'(redirect_pc[2:0]);
      if (m_out) begin
        if (rvalid) begin m_out = 0; m_drop = 0; end
        else m_drop = 1;
      end
    end else begin
      if (consume && m_valid) begin
        for (int k = 0; k < int'(consume_len); k++) void'(mq.pop_front());
        m_pc = m_pc + 64'(consume_len);
      end
      if (rvalid && m_out) begin
        if (!m_drop) begin
          for (int b = m_skip; b < 8; b++) mq.push_back(rdata[8*b +: 8]);
          m_skip = 0;
        end
        m_out = 0; m_drop = 0;
      end
      if (!pre_out && !exh(m_faddr) && pre_cnt <= 8) begin
        m_req   = 1;
        m_addr  = m_faddr;
        m_faddr = m_faddr + 64'd8;
        m_out   = 1;
      end
    end
    m_valid = (mq.size() >= 10) || (exh(m_faddr) && !m_out && mq.size() > 0);
  endtask

  // One clock: drive inputs and memory response, step model, check all outputs.
  task automatic cycle(input bit redir, input logic [63:0] rpc, input bit cons, input logic [3:0] clen);
    @(negedge clk);
    rst_n       = rst_drv;
    redirect    = redir;
    redirect_pc = rpc;
    consume     = cons;
    consume_len = clen;
    if (pend && dly == 0) begin
      rvalid = 1'b1;
      rdata  = mem_word(pend_addr);
    end else begin
      rvalid = 1'b0;
      rdata  = {$urandom, $urandom};
      if (pend) dly--;
    end
    @(posedge clk);
    model_step();
    #1;
    chk("valid", 80'(obs_valid), 80'(m_valid));
    chk("pc", 80'(obs_pc), 80'(m_pc));
    chk("instr", obs_instr, exp_instr());
    chk("req", 80'(obs_req), 80'(m_req));
    if (m_req) chk("req_addr", 80'(obs_addr), 80'(m_addr));
    rvalid_seen = rvalid;
    req_seen    = obs_req;
    if (rvalid || !rst_n) pend = 0;
    if (obs_req && rst_n) begin
      pend          = 1;
      pend_addr     = obs_addr;
      dly           = int'($urandom_range(32'(lat_max - 1), 32'(lat_min - 1)));
      last_req_addr = obs_addr;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 64'd0, 1'b0, 4'd0);
  endtask

  task automatic run_until_valid(input string tag);
    int k;
    k = 0;
    while (!m_valid && k < 40) begin idle(); k++; end
    chk(tag, 80'(obs_valid), 80'd1);
  endtask

  task automatic run_until_rvalid(input string tag);
    int k;
    k = 0;
    rvalid_seen = 0;
    while (!rvalid_seen && k < 40) begin idle(); k++; end
    chk(tag, 80'(rvalid_seen), 80'd1);
  endtask

  task automatic run_until_req(input string tag);
    int k;
    k = 0;
    req_seen = 0;
    while (!req_seen && k < 40) begin idle(); k++; end
    chk(tag, 80'(req_seen), 80'd1);
  endtask

  task automatic random_phase(input int ncyc, input int pc_max, input int rst_at);
    int          r, cnt, mx;
    bit          rd, cs;
    logic [63:0] rpc;
    logic [3:0]  len;
    for (int c = 0; c < ncyc; c++) begin
      rst_drv = !(c >= rst_at && c < rst_at + 2);
      r   = int'($urandom_range(99, 0));
      rd  = (r < 4);
      rpc = 64'($urandom_range(32'(pc_max), 0));
      if (r == 0 && pc_max > 100) rpc = {$urandom, $urandom};
      if (r == 1 && pc_max > 100) rpc = 64'($urandom_range(1023, 1000));
      cs  = 0;
      len = 4'd1;
      cnt = mq.size();
      if (m_valid && r >= 50) begin
        mx  = (cnt < 10) ? cnt : 10;
        cs  = 1;
        len = 4'($urandom_range(32'(mx), 1));
      end else if (!m_valid && cnt > 0 && r >= 80) begin
        cs  = 1;
      end
      cycle(rd, rpc, cs, len);
    end
    rst_drv = 1;
  endtask

  initial begin
    rst_n = 0; sel = 0; redirect = 0; redirect_pc = '0; consume = 0; consume_len = '0;
    rvalid = 0; rdata = '0; pend = 0; pend_addr = '0; dly = 0; rvalid_seen = 0; req_seen = 0;
    last_req_addr = '0; lat_min = 2; lat_max = 2;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h30; mem[1] = 8'hF8; mem[2] = 8'h08;
    for (int i = 3; i < 10; i++) mem[i] = 8'h00;
    mem[10] = 8'h30; mem[11] = 8'hF9; mem[12] = 8'h21;
    mem[13] = 8'h00; mem[14] = 8'h00; mem[15] = 8'h00;
    mem[16'h16] = 8'h60; mem[16'h17] = 8'h8A;

    // Reset values
    rst_drv = 0;
    repeat (3) idle();
    chk("rst_pc", 80'(obs_pc), 80'd0);
    chk("rst_valid", 80'(obs_valid), 80'd0);
    chk("rst_instr", obs_instr, 80'd0);
    chk("rst_req", 80'(obs_req), 80'd0);

    // Aligned start: first request right after release, valid after second word
    rst_drv = 1;
    idle();
    chk("t1_first_req", 80'(obs_req), 80'd1);
    chk("t1_first_addr", 80'(obs_addr), 80'h0);
    run_until_valid("t1_valid");
    chk("t1_second_addr", 80'(last_req_addr), 80'h8);
    chk("t1_pc", 80'(obs_pc), 80'h0);
    chk("t1_b01", 80'(obs_instr[15:0]), 80'hF830);
    chk("t1_b2", 80'(obs_instr[23:16]), 80'h08);

    // Consume a full 10-byte window
    cycle(1'b0, 64'd0, 1'b1, 4'd10);
    chk("t2_pc", 80'(obs_pc), 80'd10);
    chk("t2_valid", 80'(obs_valid), 80'd0);
    chk("t2_tail_zero", 80'(obs_instr[79:48]), 80'h0);
    run_until_valid("t2_valid_again");
    chk("t2_addr", 80'(last_req_addr), 80'h10);
    chk("t2_b0", 80'(obs_instr[7:0]), 80'h30);
    chk("t2_b1", 80'(obs_instr[15:8]), 80'hF9);

    // Unaligned redirect: only the bytes from 0x16 are kept
    cycle(1'b1, 64'h16, 1'b0, 4'd0);
    chk("t3_pc", 80'(obs_pc), 80'h16);
    chk("t3_flush", obs_instr, 80'h0);
    run_until_rvalid("t3_resp");
    chk("t3_addr", 80'(last_req_addr), 80'h10);
    chk("t3_two_bytes", 80'(obs_instr[15:0]), 80'h8A60);
    chk("t3_rest_zero", 80'(obs_instr[79:16]), 80'h0);
    run_until_valid("t3_valid");
    chk("t3_addr2", 80'(last_req_addr), 80'h18);
    chk("t3_pc2", 80'(obs_pc), 80'h16);

    // Redirect while a response is outstanding: stale data dropped
    cycle(1'b1, 64'h0, 1'b0, 4'd0);
    run_until_rvalid("t4_resp0");
    run_until_req("t4_req8");
    chk("t4_addr8", 80'(last_req_addr), 80'h8);
    cycle(1'b1, 64'h20, 1'b0, 4'd0);
    idle();
    chk("t4_stale_dropped", obs_instr, 80'h0);
    chk("t4_pc", 80'(obs_pc), 80'h20);
    run_until_req("t4_req20");
    chk("t4_addr20", 80'(last_req_addr), 80'h20);

    // Partial consume from a full queue
    run_until_valid("t5_valid");
    cycle(1'b0, 64'd0, 1'b1, 4'd2);
    chk("t5_pc", 80'(obs_pc), 80'h22);
    chk("t5_head", 80'(obs_instr[15:0]), 80'({mem[16'h23], mem[16'h22]}));
    chk("t5_tail", 80'(obs_instr[79:64]), 80'({mem[16'h2B], mem[16'h2A]}));

    // Small memory: fetching runs off the end, short window still valid
    sel = 1; rst_drv = 0;
    repeat (2) idle();
    rst_drv = 1;
    cycle(1'b1, 64'h1E, 1'b0, 4'd0);
    chk("t6_no_req", 80'(obs_req), 80'd0);
    run_until_valid("t6_valid");
    chk("t6_addr", 80'(last_req_addr), 80'h18);
    chk("t6_b01", 80'(obs_instr[15:0]), 80'({mem[16'h1F], mem[16'h1E]}));
    chk("t6_rest_zero", 80'(obs_instr[79:16]), 80'h0);
    repeat (3) idle();
    chk("t6_stay_valid", 80'(obs_valid), 80'd1);
    cycle(1'b0, 64'd0, 1'b1, 4'd2);
    chk("t6_drained", 80'(obs_valid), 80'd0);
    chk("t6_empty", obs_instr, 80'h0);
    chk("t6_pc", 80'(obs_pc), 80'h20);

    // Random traffic on the small memory, then on the full memory with a mid-run reset
    lat_min = 1; lat_max = 4;
    random_phase(300, 40, 1000);
    sel = 0; rst_drv = 0;
    repeat (2) idle();
    rst_drv = 1;
    random_phase(1500, 1023, 700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
